// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic {IDLE, RUN} det_state_t;

    // Widest pattern any instance may use; callers truncate the mask to their own MAX_LEN.
    localparam int unsigned MASK_W = 64;

    function automatic logic [MASK_W-1:0] len_mask(input logic [31:0] len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control and
// a saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               in_valid,
    input  logic               in,
    input  logic               clr_cnt,
    output logic               armed,
    output logic               cfg_err,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

    det_state_t         state;
    logic [MAX_LEN-1:0] history;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_nxt;
    logic               cfg_legal;
    logic               shift_en;
    logic               hit;

    always_comb begin
        cfg_legal = (pat_len != '0) && (pat_len <= FULL);
        shift_en  = (state == RUN) && in_valid && !cfg_load;
        hist_nxt  = {history[MAX_LEN-2:0], in};
        fill_nxt  = (fill == FULL) ? fill : fill + 1'b1;
        mask      = MAX_LEN'(len_mask(32'(len_q)));
        hit       = shift_en && (fill_nxt >= len_q) &&
                    (((hist_nxt ^ pat_q) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            history <= '0;
            fill    <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            armed   <= 1'b0;
            cfg_err <= 1'b0;
            match   <= 1'b0;
        end else if (cfg_load) begin
            // A load always restarts the stream; an illegal length also disarms.
            history <= '0;
            fill    <= '0;
            match   <= 1'b0;
            if (cfg_legal) begin
                state   <= RUN;
                armed   <= 1'b1;
                cfg_err <= 1'b0;
                pat_q   <= pattern;
                len_q   <= pat_len;
                ovl_q   <= overlap_en;
            end else begin
                state   <= IDLE;
                armed   <= 1'b0;
                cfg_err <= 1'b1;
            end
        end else begin
            match <= hit;
            if (shift_en) begin
                if (hit && !ovl_q) begin
                    history <= '0;
                    fill    <= '0;
                end else begin
                    history <= hist_nxt;
                    fill    <= fill_nxt;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (cfg_load | clr_cnt),
        .cnt   (match_cnt)
    );

endmodule
